// File: rtl/blinky_pkg.sv
// Shared constants and types for the blinky demo top level.
package blinky_pkg;

   localparam int CLK_HZ                = 12_000_000;
   localparam int DEFAULT_COUNTER_WIDTH = 24;
   localparam int DEFAULT_TAP_BIT       = 22;

   typedef logic [DEFAULT_COUNTER_WIDTH-1:0] counter_t;

   // Number of clock edges in one full LED4 blink period for a given tap.
   function automatic longint blink_period(input int tap_bit);
      return longint'(1) << (tap_bit + 1);
   endfunction

endpackage

// File: rtl/blinky_counter.sv
// Free-running binary counter with synchronous clear and increment enable.
module blinky_counter
   import blinky_pkg::*;
#(
   parameter int WIDTH = DEFAULT_COUNTER_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   // Power-up value comes from the initialiser so counting works without reset.
   logic [WIDTH-1:0] count_q = '0;

   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/blinky_led.sv
// Top-level demo: LED4 blinks from one counter bit, LED3..LED0 are static.
module blinky_led
   import blinky_pkg::*;
#(
   parameter int         COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
   parameter int         TAP_BIT       = DEFAULT_TAP_BIT,
   parameter logic [3:0] STATIC_LEDS   = 4'b0000
) (
   input  logic CLK,
   input  logic RST = 1'b0,
   output logic LED4,
   output logic LED3,
   output logic LED2,
   output logic LED1,
   output logic LED0
);

   if (TAP_BIT >= COUNTER_WIDTH) begin : g_bad_tap
      $error("blinky_led: TAP_BIT must be below COUNTER_WIDTH");
   end

   logic [COUNTER_WIDTH-1:0] count_w;

   blinky_counter #(
      .WIDTH (COUNTER_WIDTH)
   ) u_counter (
      .clk   (CLK),
      .clr   (RST),
      .en    (1'b1),
      .count (count_w)
   );

   // Straight from a flop output, so LED4 cannot glitch.
   assign LED4 = count_w[TAP_BIT];

   assign LED3 = STATIC_LEDS[3];
   assign LED2 = STATIC_LEDS[2];
   assign LED1 = STATIC_LEDS[1];
   assign LED0 = STATIC_LEDS[0];

endmodule

// File: tb/tb_blinky_led.sv
// Randomized-reset bench for blinky_led against an edges-since-reset model.
module tb_blinky_led;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0;
   logic rst_b = 1'b0;

   logic       led4_a, led4_b, led4_d;
   logic [3:0] lo_a, lo_b, lo_d;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: rising edges seen since power-up or the last edge with reset high.
   longint na = 0;
   longint nb = 0;
   longint nd = 0;

   blinky_led #(
      .COUNTER_WIDTH (12),
      .TAP_BIT       (10),
      .STATIC_LEDS   (4'b1010)
   ) dut_a (
      .CLK  (clk),
      .RST  (rst_a),
      .LED4 (led4_a),
      .LED3 (lo_a[3]),
      .LED2 (lo_a[2]),
      .LED1 (lo_a[1]),
      .LED0 (lo_a[0])
   );

   blinky_led #(
      .COUNTER_WIDTH (4),
      .TAP_BIT       (2),
      .STATIC_LEDS   (4'b0000)
   ) dut_b (
      .CLK  (clk),
      .RST  (rst_b),
      .LED4 (led4_b),
      .LED3 (lo_b[3]),
      .LED2 (lo_b[2]),
      .LED1 (lo_b[1]),
      .LED0 (lo_b[0])
   );

   blinky_led dut_d (
      .CLK  (clk),
      .RST  (1'b0),
      .LED4 (led4_d),
      .LED3 (lo_d[3]),
      .LED2 (lo_d[2]),
      .LED1 (lo_d[1]),
      .LED0 (lo_d[0])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected count is edges modulo 2^W; LED4 is the parity of edges / 2^TAP.
   function automatic logic [31:0] exp_cnt(input longint n, input int w);
      return 32'(n % (longint'(1) << w));
   endfunction

   function automatic logic [31:0] exp_led(input longint n, input int tap);
      return 32'((n / (longint'(1) << tap)) % 2);
   endfunction

   task automatic step();
      @(posedge clk);
      na = rst_a ? 0 : na + 1;
      nb = rst_b ? 0 : nb + 1;
      nd = nd + 1;
      #1;
      chk("a_cnt",    32'(dut_a.count_w), exp_cnt(na, 12));
      chk("a_led4",   32'(led4_a),        exp_led(na, 10));
      chk("a_static", 32'(lo_a),          32'h0000000a);
      chk("b_cnt",    32'(dut_b.count_w), exp_cnt(nb, 4));
      chk("b_led4",   32'(led4_b),        exp_led(nb, 2));
      chk("b_static", 32'(lo_b),          32'h0);
      chk("d_led4",   32'(led4_d),        exp_led(nd, 22));
      chk("d_static", 32'(lo_d),          32'h0);
   endtask

   initial begin
      // Power-up with reset low: first edge.
      step();
      chk("pwr_d_cnt", 32'(dut_d.count_w), 32'd1);

      // 101 edges on the default configuration.
      repeat (100) step();
      chk("d_cnt101",  32'(dut_d.count_w), 32'd101);
      chk("d_led4_101", 32'(led4_d), 32'd0);

      // Synthetic 4-bit counter has wrapped several times by now.
      chk("b_cnt101", 32'(dut_b.count_w), 32'd5);

      // Tap rise at 2^10 edges and fall at 2^11 on dut_a.
      repeat (1023 - 101) step();
      chk("a_pre_rise", 32'(led4_a), 32'd0);
      step();
      chk("a_rise", 32'(led4_a), 32'd1);
      repeat (1024) step();
      chk("a_fall", 32'(led4_a), 32'd0);

      // Reset, count to 1000, reset for one edge, release.
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      repeat (1000) step();
      chk("a_cnt1000", 32'(dut_a.count_w), 32'd1000);
      rst_a = 1'b1;
      step();
      chk("a_rst_cnt",  32'(dut_a.count_w), 32'd0);
      chk("a_rst_led4", 32'(led4_a), 32'd0);
      rst_a = 1'b0;
      step();
      chk("a_resume", 32'(dut_a.count_w), 32'd1);

      // Randomized reset pulses on both reset-capable instances.
      for (int i = 0; i < 3000; i++) begin
         rst_a = ($urandom_range(0, 99) < 2);
         rst_b = ($urandom_range(0, 99) < 3);
         step();
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (40) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
